// File: rtl/fc_layer_mac.sv
// Fully-connected layer: N_OUT parallel MACs over an N_IN-element input stream,
// with requantised results streamed out one neuron per valid/ready beat.
module fc_layer_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned N_IN   = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned RELU   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_we,
  input  logic [$clog2(N_OUT*N_IN+N_OUT)-1:0]    cfg_addr,
  input  logic [BIAS_W-1:0]                      cfg_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [DATA_W-1:0]               in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [DATA_W-1:0]               out_data,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out_idx,
  output logic                                   busy
);

  localparam int unsigned N_W    = N_OUT * N_IN;
  localparam int unsigned ADDR_W = $clog2(N_W + N_OUT);
  localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned CNT_W  = $clog2(N_IN);
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [CNT_W-1:0]         r_in_cnt;
  logic [IDX_W-1:0]         r_out_cnt;
  logic [IDX_W-1:0]         w_out_cnt_inc;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_busy;

  logic signed [DATA_W-1:0] r_w   [N_OUT][N_IN];
  logic signed [BIAS_W-1:0] r_b   [N_OUT];
  logic signed [ACC_W-1:0]  r_acc [N_OUT];
  logic signed [ACC_W-1:0]  w_acc_nxt [N_OUT];
  logic signed [PROD_W-1:0] w_prod    [N_OUT];

  logic w_accept;
  logic w_take;
  logic w_last_in;
  logic w_last_out;

  assign w_accept      = in_valid & r_in_ready;
  assign w_take        = r_out_valid & out_ready;
  assign w_last_in     = (r_in_cnt == CNT_W'(N_IN - 1));
  assign w_last_out    = (r_out_cnt == IDX_W'(N_OUT - 1));
  assign w_out_cnt_inc = r_out_cnt + 1'b1;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_cnt;
  assign busy      = r_busy;

  // Requantise: arithmetic shift, optional ReLU, saturate to DATA_W
  function automatic logic signed [DATA_W-1:0] f_q(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if ((RELU != 0) && s[ACC_W-1]) s = '0;
    if (s > Q_MAX)      s = Q_MAX;
    else if (s < Q_MIN) s = Q_MIN;
    return s[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_accept && w_last_in) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_take && w_last_out) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // First accept of a vector seeds each accumulator with its bias
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      w_prod[o]    = $signed(in_data) * r_w[o][r_in_cnt];
      w_acc_nxt[o] = ((r_state == S_IDLE) ? ACC_W'(r_b[o]) : r_acc[o]) + ACC_W'(w_prod[o]);
    end
  end

  // Weight/bias memory: writable only while idle, not reset
  always_ff @(posedge clk) begin
    if (cfg_we && (r_state == S_IDLE)) begin
      for (int o = 0; o < N_OUT; o++) begin
        for (int i = 0; i < N_IN; i++) begin
          if (cfg_addr == ADDR_W'(o * N_IN + i)) r_w[o][i] <= cfg_data[DATA_W-1:0];
        end
        if (cfg_addr == ADDR_W'(N_W + o)) r_b[o] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      for (int o = 0; o < N_OUT; o++) r_acc[o] <= '0;
    end else begin
      r_in_ready <= (w_state_nxt != S_DRAIN);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        for (int o = 0; o < N_OUT; o++) r_acc[o] <= w_acc_nxt[o];
        r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
      end
      // Neuron 0 is requantised straight from the final MAC result
      if (w_accept && w_last_in) begin
        r_out_valid <= 1'b1;
        r_out_data  <= f_q(w_acc_nxt[0]);
        r_out_cnt   <= '0;
      end else if (w_take) begin
        if (w_last_out) begin
          r_out_valid <= 1'b0;
          r_out_cnt   <= '0;
        end else begin
          r_out_cnt  <= w_out_cnt_inc;
          r_out_data <= f_q(r_acc[w_out_cnt_inc]);
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_mac.sv
// Bench for fc_layer_mac: RELU=1 and RELU=0 instances share stimulus and are
// checked every cycle against an arithmetic model plus literal result vectors.
module tb_fc_layer_mac;
  localparam int DATA_W = 8;
  localparam int N_IN   = 8;
  localparam int N_OUT  = 4;
  localparam int SHIFT  = 4;
  localparam int ADDR_W = 6;
  localparam int IDX_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [15:0]              cfg_data;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_ready;

  logic                     ir_r, ov_r, busy_r, ir_n, ov_n, busy_n;
  logic signed [DATA_W-1:0] od_r, od_n;
  logic [IDX_W-1:0]         oi_r, oi_n;

  fc_layer_mac #(.RELU(1)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(ir_r), .in_data(in_data),
    .out_valid(ov_r), .out_ready(out_ready), .out_data(od_r), .out_idx(oi_r), .busy(busy_r)
  );

  fc_layer_mac #(.RELU(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(ir_n), .in_data(in_data),
    .out_valid(ov_n), .out_ready(out_ready), .out_data(od_n), .out_idx(oi_n), .busy(busy_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Model state
  int mw [N_OUT][N_IN];
  int mb [N_OUT];
  int macc [N_OUT];
  int m_cnt = 0;
  int eq_idx[$], eq_r[$], eq_n[$];
  int log_idx[$], log_r[$], log_n[$];

  function automatic int qz(input int a, input int relu);
    int s;
    s = a >>> SHIFT;
    if (relu != 0 && s < 0) s = 0;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // Compare every cycle, then advance the model by what the next edge will do
  always @(negedge clk) begin
    bit empty, idle;
    int a;
    if (!rst_n) begin
      m_cnt = 0;
      eq_idx.delete(); eq_r.delete(); eq_n.delete();
      chk("rst_out_valid", int'(ov_r), 0);
      chk("rst_out_valid_n", int'(ov_n), 0);
      chk("rst_in_ready", int'(ir_r), 1);
      chk("rst_busy", int'(busy_r), 0);
      chk("rst_out_data", int'(od_r), 0);
      chk("rst_out_idx", int'(oi_r), 0);
    end else begin
      empty = (eq_idx.size() == 0);
      idle  = empty && (m_cnt == 0);
      chk("out_valid", int'(ov_r), int'(!empty));
      chk("out_valid_n", int'(ov_n), int'(!empty));
      chk("in_ready", int'(ir_r), int'(empty));
      chk("in_ready_n", int'(ir_n), int'(empty));
      chk("busy", int'(busy_r), int'((m_cnt != 0) || !empty));
      chk("busy_n", int'(busy_n), int'((m_cnt != 0) || !empty));
      if (!empty) begin
        chk("out_data", int'(od_r), eq_r[0]);
        chk("out_data_n", int'(od_n), eq_n[0]);
        chk("out_idx", int'(oi_r), eq_idx[0]);
        chk("out_idx_n", int'(oi_n), eq_idx[0]);
        if (out_ready) begin
          log_r.push_back(int'(od_r));
          log_n.push_back(int'(od_n));
          log_idx.push_back(int'(oi_r));
          void'(eq_idx.pop_front()); void'(eq_r.pop_front()); void'(eq_n.pop_front());
        end
      end
      if (empty && in_valid) begin
        for (int o = 0; o < N_OUT; o++) begin
          if (m_cnt == 0) macc[o] = mb[o];
          macc[o] += int'(in_data) * mw[o][m_cnt];
        end
        m_cnt++;
        if (m_cnt == N_IN) begin
          m_cnt = 0;
          for (int o = 0; o < N_OUT; o++) begin
            eq_idx.push_back(o);
            eq_r.push_back(qz(macc[o], 1));
            eq_n.push_back(qz(macc[o], 0));
          end
        end
      end
      if (cfg_we && idle) begin
        a = int'(cfg_addr);
        if (a < N_OUT * N_IN) mw[a / N_IN][a % N_IN] = int'($signed(cfg_data[7:0]));
        else if (a < N_OUT * N_IN + N_OUT) mb[a - N_OUT * N_IN] = int'($signed(cfg_data));
      end
    end
  end

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_data = 16'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // mode 0: every weight = wc; mode 1: W[o][i] = o+1. Bias B[o] = bstep*o.
  task automatic load(input int mode, input int wc, input int bstep);
    for (int o = 0; o < N_OUT; o++)
      for (int i = 0; i < N_IN; i++) cfg_wr(o * N_IN + i, (mode == 0) ? wc : o + 1);
    for (int o = 0; o < N_OUT; o++) cfg_wr(N_OUT * N_IN + o, bstep * o);
  endtask

  // Hold in_valid until n beats are accepted; optionally pulse a cfg write after cfg_at accepts
  task automatic feed(input int n, input int val, input int cfg_at, input int ca, input int cd,
                      output int cycles);
    int acc;
    acc = 0; cycles = 0;
    in_valid = 1'b1; in_data = DATA_W'(val);
    while (acc < n && cycles < 200) begin
      @(negedge clk);
      if (ir_r) acc++;
      @(posedge clk); #1;
      cycles++;
      cfg_we = (acc == cfg_at); cfg_addr = ADDR_W'(ca); cfg_data = 16'(cd);
    end
    in_valid = 1'b0; cfg_we = 1'b0;
    chk("feed_accepts", acc, n);
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while (eq_idx.size() != 0 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("drain_timeout", eq_idx.size(), 0);
  endtask

  task automatic clr_log();
    log_r.delete(); log_n.delete(); log_idx.delete();
  endtask

  task automatic chk_vec(input string nm, input int er[N_OUT], input int en[N_OUT]);
    chk({nm, "_count"}, log_r.size(), N_OUT);
    for (int k = 0; k < N_OUT && k < log_r.size(); k++) begin
      chk({nm, "_relu"}, log_r[k], er[k]);
      chk({nm, "_norelu"}, log_n[k], en[k]);
      chk({nm, "_idx"}, log_idx[k], k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Unit weights, zero bias, inputs 16 -> 8 on every neuron
    load(0, 1, 0);
    clr_log();
    feed(8, 16, -1, 0, 0, cyc);
    chk("s1_latency_valid", int'(ov_r), 1);
    chk("s1_latency_idx", int'(oi_r), 0);
    drain(cyc);
    chk("s1_drain_cycles", cyc, 4);
    chk_vec("s1", '{8, 8, 8, 8}, '{8, 8, 8, 8});

    // Back-to-back vector starts the cycle after the last handshake
    clr_log();
    feed(8, 16, -1, 0, 0, cyc);
    chk("b2b_feed_cycles", cyc, 8);
    drain(cyc);
    chk_vec("b2b", '{8, 8, 8, 8}, '{8, 8, 8, 8});

    // Reset mid-ACCUM
    feed(5, 16, -1, 0, 0, cyc);
    rst_n = 1'b0; #1;
    chk("rst_accum_busy", int'(busy_r), 0);
    chk("rst_accum_in_ready", int'(ir_r), 1);
    chk("rst_accum_valid", int'(ov_r), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clr_log();
    feed(8, 16, -1, 0, 0, cyc);
    drain(cyc);
    chk_vec("post_rst", '{8, 8, 8, 8}, '{8, 8, 8, 8});

    // Reset mid-DRAIN: partial results never emitted
    out_ready = 1'b0;
    feed(8, 16, -1, 0, 0, cyc);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rst_drain_valid", int'(ov_r), 0);
    chk("rst_drain_in_ready", int'(ir_r), 1);
    chk("rst_drain_data", int'(od_r), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // cfg write during ACCUM ignored, now and for the next vector
    clr_log();
    feed(8, 16, 3, 0, 5, cyc);
    drain(cyc);
    chk_vec("cfg_accum", '{8, 8, 8, 8}, '{8, 8, 8, 8});
    clr_log();
    feed(8, 16, -1, 0, 0, cyc);
    drain(cyc);
    chk_vec("cfg_next", '{8, 8, 8, 8}, '{8, 8, 8, 8});

    // W[o][i]=o+1, B[o]=16o
    load(1, 0, 16);
    clr_log();
    feed(8, 16, -1, 0, 0, cyc);
    drain(cyc);
    chk_vec("s2", '{8, 17, 26, 35}, '{8, 17, 26, 35});

    // Backpressure with in_valid held through DRAIN
    clr_log();
    out_ready = 1'b0;
    feed(8, 16, -1, 0, 0, cyc);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_data", int'(od_r), 8);
      chk("bp_hold_idx", int'(oi_r), 0);
      chk("bp_in_ready", int'(ir_r), 0);
      @(posedge clk); #1;
    end
    cyc = 0;
    while (eq_idx.size() != 0 && cyc < 40) begin
      out_ready = ~out_ready;
      @(negedge clk);
      if (eq_idx.size() != 0 || out_ready) chk("bp_drain_in_ready", int'(ir_r), 0);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    chk_vec("bp", '{8, 17, 26, 35}, '{8, 17, 26, 35});
    clr_log();
    feed(8, 16, -1, 0, 0, cyc);
    drain(cyc);
    chk_vec("bp_next", '{8, 17, 26, 35}, '{8, 17, 26, 35});

    // Saturation high
    load(0, 127, 0);
    clr_log();
    feed(8, 127, -1, 0, 0, cyc);
    drain(cyc);
    chk_vec("sat_hi", '{127, 127, 127, 127}, '{127, 127, 127, 127});

    // Saturation low / ReLU
    load(0, -128, 0);
    clr_log();
    feed(8, 127, -1, 0, 0, cyc);
    drain(cyc);
    chk_vec("sat_lo", '{0, 0, 0, 0}, '{-128, -128, -128, -128});

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_mac.md
Name: fc_layer_mac

Overview:
Parametrised fully-connected layer that generalises the single-neuron fc_dotprod to N_OUT neurons over an N_IN-element input vector. It holds a loadable weight/bias memory and uses N_OUT parallel MACs, one multiply-accumulate per neuron per accepted input. Each accumulator is requantised with an arithmetic right shift, optional ReLU and saturation. Results leave as a serial valid/ready stream, one neuron per beat. The block sits between the pooling/flatten stage and the classifier output.

Parameters:
DATA_W, 8, signed width of activations, weights and outputs
ACC_W, 24, signed accumulator width; must be >= 2*DATA_W + clog2(N_IN) + 1
BIAS_W, 16, signed bias width, sign-extended into the accumulator
N_IN, 8, input vector length (>= 2)
N_OUT, 4, number of output neurons (>= 1)
SHIFT, 4, requantisation arithmetic right shift (0..ACC_W-1)
RELU, 1, 1 = clamp negative results to 0 before saturation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  weight/bias write strobe
cfg_addr  in  clog2(N_OUT*N_IN+N_OUT)  addresses o*N_IN+i are weight W[o][i]; addresses N_OUT*N_IN+o are bias B[o]
cfg_data  in  BIAS_W  write data; weights use bits [DATA_W-1:0]
in_valid  in  1  input element valid
in_ready  out  1  block can accept an input element
in_data  in  DATA_W  signed input element
out_valid  out  1  output result valid
out_ready  in  1  downstream accepts the result
out_data  out  DATA_W  signed requantised neuron result
out_idx  out  clog2(N_OUT)  neuron index of out_data
busy  out  1  high in ACCUM or DRAIN

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_cnt=0, out_cnt=0, out_valid=0, out_data=0, out_idx=0, busy=0, in_ready=1. Accumulators are cleared. Weight/bias memory is not reset; its contents are undefined until written.
- Input accept: a beat is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. cfg_we writes memory in this state only; cfg_we is ignored in ACCUM and DRAIN. On the first accept, acc[o] = sext(B[o]) + in_data*W[o][0] for every o, in_cnt=1, go to ACCUM.
  - ACCUM: in_ready=1. Each accept does acc[o] += in_data*W[o][in_cnt] and in_cnt++. The accept that makes in_cnt reach N_IN goes to DRAIN, with in_cnt reset to 0.
  - DRAIN: in_ready=0. out_valid=1 starting the cycle after the last input accept (1-cycle latency). out_data=q(acc[out_cnt]) and out_idx=out_cnt, both registered and stable while out_valid && !out_ready. On out_valid && out_ready, out_cnt++. After index N_OUT-1 is taken, out_valid drops, out_cnt=0, and the state returns to IDLE; in_ready=1 in that same cycle.
- Arithmetic:
  - Products are full 2*DATA_W signed; accumulation is ACC_W signed with no overflow checking (guaranteed by the parameter constraint).
  - q(a): s = a >>> SHIFT (arithmetic). If RELU and s<0 then s=0. Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Boundary conditions:
  - in_valid held during DRAIN is not accepted; the data must be held by the source.
  - out_ready may toggle arbitrarily; no result is dropped or duplicated.
  - Reset asserted mid-ACCUM or mid-DRAIN aborts the vector immediately. Partial results are never emitted.
  - Back-to-back vectors: the first element of the next vector may be accepted in the cycle after the last output handshake.

Test Plan:
- All weights=1, biases=0, SHIFT=4, RELU=1. Feed 8 inputs of 16 (in_valid held). Required: out_data=8 with out_idx 0,1,2,3 on 4 consecutive cycles, first one the cycle after the 8th accept.
- W[o][i]=o+1, B[o]=16*o, inputs all 16. Required: acc = 128(o+1)+16o, giving out_data 8, 17, 26, 35 for o=0..3.
- Saturation: all W=127, inputs 127, B=0. acc=129032, >>>4 = 8064, so out=127. Same run with W=-128 and RELU=0: acc=-130048, >>>4 = -8128, so out=-128. Same run with RELU=1: out=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises, then toggled 1/0. Required: out_data/out_idx stable while stalled, exactly 4 handshakes, in_ready=0 throughout DRAIN.
- Reset mid-operation: drop rst_n after the 5th input. Required: all outputs return to reset values immediately. A following full 8-input vector produces the correct results of scenario 1.
- cfg_we pulsed during ACCUM with a new W[0][0]. Required: the write is ignored, the results are unchanged, and the next vector still uses the old weight.
